uart_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one Hamming(7,4) encoder and one UART transmitter between NREQ nibble requesters.
- Each requester posts a 4-bit nibble and receives a one-cycle done or error pulse when service ends.
- The block sequences the full transfer: encoder enable pulse, capture of the code, tx_start handshake against tx_busy, and end-of-frame detection.
- It sits between the user-facing inputs and the existing encoder and transmitter instances, and replaces ad-hoc edge-detect and start-stretch glue.

---
 rtl/uart_tx_scheduler.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one Hamming(7,4) encoder and one UART transmitter
// between NREQ nibble requesters; sequences encode, start handshake and frame end.
module uart_tx_scheduler #(
   parameter int  NREQ    = 4,
   parameter int  TIMEOUT = 255,
   localparam int GW      = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   err,
   output logic              enc_ena,
   output logic [3:0]        enc_data,
   input  logic [6:0]        enc_code,
   input  logic              enc_valid,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              busy,
   output logic [GW-1:0]     grant_id
);

   typedef enum logic [2:0] {
      S_IDLE, S_ENC, S_WAIT_ENC, S_START, S_SEND, S_DONE, S_ERR
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [NREQ-1:0]   pending_q, pending_d;
   logic [3:0]        hold_q [NREQ];
   logic [3:0]        hold_d [NREQ];
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     last_q, last_d;
   logic [3:0]        enc_data_q, enc_data_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [7:0]        cnt_q, cnt_d;

   logic              found;
   logic [GW-1:0]     pick;
   logic [GW-1:0]     cand;

   // Round-robin search starting just after the most recently served requester.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = GW'((int'(last_q) + k) % NREQ);
         if (!found && pending_q[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      pending_d  = pending_q;
      hold_d     = hold_q;
      grant_d    = grant_q;
      last_d     = last_q;
      enc_data_d = enc_data_q;
      tx_data_d  = tx_data_q;
      cnt_d      = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d    = pick;
               enc_data_d = hold_q[pick];
               state_d    = S_ENC;
            end
         end
         S_ENC: begin
            cnt_d   = '0;
            state_d = S_WAIT_ENC;
         end
         S_WAIT_ENC: begin
            if (enc_valid) begin
               tx_data_d = {1'b0, enc_code};
               cnt_d     = '0;
               state_d   = S_START;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_START: begin
            if (tx_busy) begin
               state_d = S_SEND;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_SEND: begin
            if (!tx_busy) state_d = S_DONE;
         end
         S_DONE, S_ERR: begin
            pending_d[grant_q] = 1'b0;
            last_d             = grant_q;
            state_d            = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Capture runs after the clear above, so a request landing on the
      // requester's own DONE/ERR cycle re-queues with fresh data.
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && !pending_d[i]) begin
            pending_d[i] = 1'b1;
            hold_d[i]    = req_data[4*i +: 4];
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         // NOTE: the nibble holding array is small and must read as zero after reset, so it is reset.
         hold_q     <= '{default: '0};
         grant_q    <= '0;
         last_q     <= GW'(NREQ - 1);
         enc_data_q <= '0;
         tx_data_q  <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         hold_q     <= hold_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         enc_data_q <= enc_data_d;
         tx_data_q  <= tx_data_d;
         cnt_q      <= cnt_d;
      end
   end

   // Strobes decode straight from state so reset removes them without waiting for a clock.
   logic [NREQ-1:0] grant_mask;
   assign grant_mask = NREQ'(1) << grant_q;

   assign enc_ena  = (state_q == S_ENC);
   assign tx_start = (state_q == S_START);
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE) ? grant_mask : '0;
   assign err      = (state_q == S_ERR)  ? grant_mask : '0;
   assign enc_data = enc_data_q;
   assign tx_data  = tx_data_q;
   assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: behavioural encoder and UART models,
// scoreboard of expected services, table-driven vectors plus corner-case sequences.
module tb_uart_tx_scheduler;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 8;
   localparam int GW      = 2;
   localparam int FRAME   = 6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [4*NREQ-1:0] req_data;
   logic [NREQ-1:0]   done;
   logic [NREQ-1:0]   err;
   logic              enc_ena;
   logic [3:0]        enc_data;
   logic [6:0]        enc_code;
   logic              enc_valid;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic              busy;
   logic [GW-1:0]     grant_id;

   bit enc_on  = 1'b1;
   bit uart_on = 1'b1;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .done      (done),
      .err       (err),
      .enc_ena   (enc_ena),
      .enc_data  (enc_data),
      .enc_code  (enc_code),
      .enc_valid (enc_valid),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   typedef struct {
      int         id;
      logic [3:0] nib;
      bit         is_err;
   } exp_t;

   typedef struct {
      logic [3:0]      req;
      logic [15:0]     data;
      int              n;
      logic [3:0][1:0] order;
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Stand-in encoder mapping: distinct per nibble, 0xB -> 0x55.
   function automatic logic [6:0] enc_fn(input logic [3:0] n);
      return 7'h55 ^ {3'b000, n ^ 4'hB};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit evt(input int kind, input int idx);
      case (kind)
         0:       return done[idx];
         1:       return tx_busy;
         2:       return enc_ena;
         default: return tx_start;
      endcase
   endfunction

   task automatic wait_evt(input int kind, input int idx, input string name);
      int cyc = 0;
      while (!evt(kind, idx) && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check(name, 32'(evt(kind, idx)), 32'd1);
   endtask

   task automatic push(input int id, input logic [3:0] nib, input bit is_err);
      exp_t e;
      e.id = id; e.nib = nib; e.is_err = is_err;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int cyc = 0;
      while ((sb.size() != 0 || busy) && cyc < 600) begin
         @(negedge clk);
         cyc++;
      end
      check(name, 32'(sb.size() == 0 && !busy), 32'd1);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      req      = '0;
      req_data = '0;
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Encoder model: returns the code two cycles after the enable pulse.
   initial begin : enc_model
      logic [3:0] n;
      enc_valid = 1'b0;
      enc_code  = '0;
      forever begin
         @(negedge clk);
         if (rst_n && enc_ena && enc_on) begin
            n = enc_data;
            @(posedge clk);
            @(posedge clk);
            #1;
            enc_code  = enc_fn(n);
            enc_valid = 1'b1;
            @(posedge clk);
            #1;
            enc_valid = 1'b0;
         end
      end
   end

   // UART model: busy rises two cycles after start is seen, holds for FRAME cycles.
   initial begin : uart_model
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && tx_start && uart_on) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            tx_busy = 1'b1;
            for (int k = 0; k < FRAME; k++) begin
               @(posedge clk);
               if (!rst_n) break;
            end
            #1;
            tx_busy = 1'b0;
         end
      end
   end

   // Monitor: compares every DUT event against the front of the scoreboard.
   initial begin : monitor
      exp_t e;
      logic prev_busy, prev_start, rose;
      prev_busy = 1'b0; prev_start = 1'b0; rose = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_busy = 1'b0; prev_start = 1'b0; rose = 1'b0;
         end else begin
            if (enc_ena) begin
               if (sb.size() == 0) check("enc_unexpected", 32'd1, 32'd0);
               else begin
                  e = sb[0];
                  check("grant_id", 32'(grant_id), e.id);
                  check("enc_data", 32'(enc_data), 32'(e.nib));
               end
            end
            if (tx_start && !prev_start) check("start_no_overlap", 32'(tx_busy), 32'd0);
            if (rose) check("start_drop", 32'(tx_start), 32'd0);
            rose = tx_busy && !prev_busy;
            if (rose) begin
               check("start_held", 32'(tx_start), 32'd1);
               if (sb.size() != 0) check("tx_data", 32'(tx_data), 32'({1'b0, enc_fn(sb[0].nib)}));
            end
            if (done != '0 || err != '0) begin
               check("done_err_excl", 32'(done & err), 32'd0);
               if (sb.size() == 0) check("pulse_unexpected", 32'd1, 32'd0);
               else begin
                  e = sb.pop_front();
                  check("done", 32'(done), e.is_err ? 32'd0 : (32'd1 << e.id));
                  check("err",  32'(err),  e.is_err ? (32'd1 << e.id) : 32'd0);
               end
            end
            prev_busy  = tx_busy;
            prev_start = tx_start;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      vec_t vecs [5];
      int   cnt;
      vecs[0] = '{req: 4'b0001, data: 16'h000B, n: 1, order: {2'd0, 2'd0, 2'd0, 2'd0}};
      vecs[1] = '{req: 4'b1111, data: 16'h4321, n: 4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
      vecs[2] = '{req: 4'b0100, data: 16'h0000, n: 1, order: {2'd0, 2'd0, 2'd0, 2'd2}};
      vecs[3] = '{req: 4'b1000, data: 16'hF000, n: 1, order: {2'd0, 2'd0, 2'd0, 2'd3}};
      vecs[4] = '{req: 4'b1010, data: 16'hA0C0, n: 2, order: {2'd0, 2'd0, 2'd3, 2'd1}};

      do_reset();
      check("rst_done",     32'(done),     32'd0);
      check("rst_err",      32'(err),      32'd0);
      check("rst_enc_ena",  32'(enc_ena),  32'd0);
      check("rst_enc_data", 32'(enc_data), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data",  32'(tx_data),  32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);

      foreach (vecs[v]) begin
         do_reset();
         for (int k = 0; k < vecs[v].n; k++)
            push(int'(vecs[v].order[k]), vecs[v].data[4*vecs[v].order[k] +: 4], 1'b0);
         req      = vecs[v].req;
         req_data = vecs[v].data;
         @(negedge clk);
         req = '0;
         drain($sformatf("vec%0d_drain", v));
         @(negedge clk);
         check($sformatf("vec%0d_idle", v), 32'(busy), 32'd0);
      end

      // Fairness: requester 2 held, requester 1 pulsed mid-frame -> 2,1,2.
      do_reset();
      push(2, 4'h5, 1'b0);
      push(1, 4'h9, 1'b0);
      push(2, 4'h5, 1'b0);
      req = 4'b0100; req_data = 16'h0500;
      wait_evt(1, 0, "fair_busy");
      @(negedge clk);
      req = 4'b0110; req_data = 16'h0590;
      @(negedge clk);
      req = 4'b0100;
      wait_evt(0, 1, "fair_done1");
      @(negedge clk);
      wait_evt(2, 0, "fair_enc2");
      req = '0;
      drain("fair_drain");

      // Collision: re-request lands on requester 1's DONE cycle.
      do_reset();
      push(1, 4'h3, 1'b0);
      req = 4'b0010; req_data = 16'h0030;
      @(negedge clk);
      req = '0;
      wait_evt(0, 1, "coll_done");
      req = 4'b0010; req_data = 16'h0070;
      push(1, 4'h7, 1'b0);
      @(negedge clk);
      req = '0;
      drain("coll_drain");

      // Start timeout: UART never answers.
      do_reset();
      uart_on = 1'b0;
      push(0, 4'hC, 1'b1);
      req = 4'b0001; req_data = 16'h000C;
      @(negedge clk);
      req = '0;
      wait_evt(3, 0, "to_start");
      cnt = 0;
      while (tx_start && cnt < 50) begin
         cnt++;
         @(negedge clk);
      end
      check("to_start_len", cnt, TIMEOUT);
      drain("to_drain");
      repeat (5) @(negedge clk);
      check("to_no_requeue", 32'(busy), 32'd0);
      uart_on = 1'b1;

      // Encoder timeout: no enc_valid ever.
      do_reset();
      enc_on = 1'b0;
      push(2, 4'h1, 1'b1);
      req = 4'b0100; req_data = 16'h0100;
      @(negedge clk);
      req = '0;
      drain("enc_to_drain");
      enc_on = 1'b1;

      // Reset during SEND.
      do_reset();
      push(0, 4'hA, 1'b0);
      req = 4'b0001; req_data = 16'h000A;
      @(negedge clk);
      req = '0;
      wait_evt(1, 0, "mid_busy");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_done",     32'(done),     32'd0);
      check("mid_err",      32'(err),      32'd0);
      check("mid_enc_ena",  32'(enc_ena),  32'd0);
      check("mid_enc_data", 32'(enc_data), 32'd0);
      check("mid_tx_start", 32'(tx_start), 32'd0);
      check("mid_tx_data",  32'(tx_data),  32'd0);
      check("mid_busy_out", 32'(busy),     32'd0);
      check("mid_grant_id", 32'(grant_id), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_quiet", 32'(busy), 32'd0);
      push(3, 4'h6, 1'b0);
      req = 4'b1000; req_data = 16'h6000;
      @(negedge clk);
      req = '0;
      drain("mid_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
